// File: rtl/float_add_pipe_if.sv
// Operand/result bundle for float_add_pipe: valid/ready on both sides.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the adder; out_ready from the consumer.
interface float_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [2:0]   flags;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, flags
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, flags
  );
endinterface

// File: rtl/float_add_pipe.sv
// Pipelined float add/sub: align, add, normalise, round/pack; flush-to-zero, canonical NaN.
// Latency: operands accepted at edge N appear on sum/out_valid after edge N+3; 1 op/cycle.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !stall. Macro FLOAT_ADD_RNE_EN selects RNE (else truncate).
module float_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic             clk,
  input logic             rst,
  float_add_pipe_if.slave io
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;  // hidden + mantissa + guard, round, sticky
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;  // signed exponent headroom
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic s1_vld, s2_vld, s3_vld, out_vld;
  logic [W-1:0] sum_q;
  logic [2:0]   flags_q;
  logic stall;

  assign stall        = out_vld && !io.out_ready;
  assign io.in_ready  = !stall;
  assign io.out_valid = out_vld;
  assign io.sum       = sum_q;
  assign io.flags     = flags_q;

  // ---------------- stage 1: classify, swap, align ----------------
  logic a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_s    = io.a[W-1];
  assign a_e    = io.a[W-2:MAN_W];
  assign a_m    = io.a[MAN_W-1:0];
  assign b_s    = io.b[W-1] ^ io.sub;  // effective sign of b
  assign b_e    = io.b[W-2:MAN_W];
  assign b_m    = io.b[MAN_W-1:0];
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);

  logic         sp_d, sp_inv_d;
  logic [W-1:0] sp_res_d;

  // Special-operand result; these bypass the arithmetic path entirely
  always_comb begin
    sp_d     = 1'b1;
    sp_inv_d = 1'b0;
    sp_res_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      sp_res_d = QNAN;
      sp_inv_d = 1'b1;
    end else if (a_inf)            sp_res_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_inf)                sp_res_d = {b_s, EXP_ONES, {MAN_W{1'b0}}};
    else if (a_zero && b_zero)     sp_res_d = {a_s & b_s, {(W-1){1'b0}}};
    else if (a_zero)               sp_res_d = {b_s, b_e, b_m};
    else if (b_zero)               sp_res_d = io.a;
    else                           sp_d = 1'b0;
  end

  logic             a_big, l_s;
  logic [EXP_W-1:0] l_e, s_e, d;
  logic [MAN_W-1:0] l_m, s_m;
  logic [SW-1:0]    s_ext, s_shf, s_al;

  assign a_big = {a_e, a_m} >= {b_e, b_m};

  // Put the larger magnitude in L and shift the smaller significand right with sticky
  always_comb begin
    l_s   = a_big ? a_s : b_s;
    l_e   = a_big ? a_e : b_e;
    l_m   = a_big ? a_m : b_m;
    s_e   = a_big ? b_e : a_e;
    s_m   = a_big ? b_m : a_m;
    d     = l_e - s_e;
    s_ext = {1'b1, s_m, 3'b000};
    s_shf = s_ext >> d;
    if (32'(d) >= SW - 1) s_al = SW'(1);
    else s_al = {s_shf[SW-1:1], s_shf[0] | (|(s_ext & ~({SW{1'b1}} << d)))};
  end

  logic             s1_sp, s1_inv, s1_sign, s1_sub;
  logic [W-1:0]     s1_res;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W:0]   s1_lsig;
  logic [SW-1:0]    s1_ssig;

  // ---------------- stage 2: significand add/subtract ----------------
  logic [SW:0] add_d;
  assign add_d = s1_sub ? ({1'b0, s1_lsig, 3'b000} - {1'b0, s1_ssig})
                        : ({1'b0, s1_lsig, 3'b000} + {1'b0, s1_ssig});

  logic             s2_sp, s2_inv, s2_sign;
  logic [W-1:0]     s2_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0]      s2_sig;

  // ---------------- stage 3: normalise ----------------
  logic [LZW-1:0] lzc;
  logic           found;
  logic [SW-1:0]  nrm_d;
  logic [XW-1:0]  exp_d;

  // Leading-zero count, then right-shift on carry-out or left-shift by lzc
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (s2_sig[i]) found = 1'b1;
        else lzc = lzc + LZW'(1);
      end
    end
    if (s2_sig[SW]) begin
      nrm_d = {s2_sig[SW:2], s2_sig[1] | s2_sig[0]};
      exp_d = XW'(s2_exp) + XW'(1);
    end else begin
      nrm_d = s2_sig[SW-1:0] << lzc;
      exp_d = XW'(s2_exp) - XW'(lzc);
    end
  end

  logic             s3_sp, s3_inv, s3_sign, s3_zero;
  logic [W-1:0]     s3_res;
  logic [XW-1:0]    s3_exp;
  logic [SW-1:0]    s3_nrm;

  // ---------------- output: round and pack ----------------
  logic             g, r, st, inc, inexact;
  logic [MAN_W-1:0] man;
  logic [MAN_W:0]   man_r;
  logic [XW-1:0]    exp_r;
  logic [W-1:0]     sum_d;
  logic [2:0]       flags_d;

  assign man     = s3_nrm[SW-2:3];
  assign g       = s3_nrm[2];
  assign r       = s3_nrm[1];
  assign st      = s3_nrm[0];
  assign inexact = g | r | st;
`ifdef FLOAT_ADD_RNE_EN
  assign inc = g & (r | st | man[0]);
`else
  assign inc = 1'b0;
`endif
  assign man_r = {1'b0, man} + {{MAN_W{1'b0}}, inc};
  assign exp_r = s3_exp + XW'(man_r[MAN_W]);

  // Final result selection: special, exact zero, underflow, overflow, normal
  always_comb begin
    sum_d   = '0;
    flags_d = '0;
    if (s3_sp) begin
      sum_d   = s3_res;
      flags_d = {s3_inv, 2'b00};
    end else if (s3_zero) begin
      sum_d = '0;
    end else if (s3_exp[XW-1] || (s3_exp == '0)) begin
      sum_d   = {s3_sign, {(W-1){1'b0}}};
      flags_d = 3'b001;
    end else if (exp_r >= XW'(EXP_ONES)) begin
      sum_d   = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 3'b011;
    end else begin
      sum_d   = {s3_sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags_d = {2'b00, inexact};
    end
  end

  // Valid bits and output registers advance together unless the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      out_vld <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else if (!stall) begin
      s1_vld  <= io.in_valid;
      s2_vld  <= s1_vld;
      s3_vld  <= s2_vld;
      out_vld <= s3_vld;
      if (s3_vld) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  // Stage data registers; contents are only meaningful under the matching valid bit
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sp   <= sp_d;
      s1_inv  <= sp_inv_d;
      s1_res  <= sp_res_d;
      s1_sign <= l_s;
      s1_sub  <= a_s ^ b_s;
      s1_exp  <= l_e;
      s1_lsig <= {1'b1, l_m};
      s1_ssig <= s_al;
      s2_sp   <= s1_sp;
      s2_inv  <= s1_inv;
      s2_res  <= s1_res;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_sig  <= add_d;
      s3_sp   <= s2_sp;
      s3_inv  <= s2_inv;
      s3_res  <= s2_res;
      s3_sign <= s2_sign;
      s3_zero <= (s2_sig == '0);  // exact cancellation yields +0
      s3_exp  <= exp_d;
      s3_nrm  <= nrm_d;
    end
  end
endmodule

// File: tb/tb_float_add_pipe.sv
// Directed bench for float_add_pipe: vector table, streaming with a stall, reset mid-stall.
// Latency: expects results 3 edges after acceptance.
// Backpressure: drives out_ready low for 4 cycles mid-stream and checks hold behaviour.
module tb_float_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_add_pipe_if bus ();
  float_add_pipe dut (.clk(clk), .rst(rst), .io(bus));

`ifdef FLOAT_ADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic [2:0]  flags;
  } vec_t;

  vec_t        vt[18];
  logic [31:0] fint[10];  // integers 0..9 as single-precision floats

  // Issue one op, wait (bounded) for its result, report latency in edges after acceptance
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] res, output logic [2:0] f, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = bus.sum;
    f   = bus.flags;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [2:0]  f;
    int          lat, tx, rx, stall_cycles;
    logic        prev_stall;
    logic [31:0] prev_sum;

    fint = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vt[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
    vt[2]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000};
    vt[3]  = '{32'h3F800000, 32'h33C00000, 1'b0, RNE ? 32'h3F800001 : 32'h3F800000, 3'b001};
    vt[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
    vt[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    vt[6]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    vt[7]  = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000};
    vt[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vt[9]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000};
    vt[10] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    vt[11] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
    vt[12] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
    vt[13] = '{32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 3'b001};
    vt[14] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000};
    vt[15] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001};
    vt[16] = '{32'h3F800000, 32'h3F800001, 1'b0, 32'h40000000, 3'b001};
    vt[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF,
               RNE ? 3'b011 : 3'b001};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_sum", bus.sum, 32'd0);
    chk("rst_flags", {29'b0, bus.flags}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // Table of directed vectors, one op at a time
    for (int i = 0; i < 18; i++) begin
      run_one(vt[i].a, vt[i].b, vt[i].sub, res, f, lat);
      chk($sformatf("vec%0d_sum", i), res, vt[i].sum);
      chk($sformatf("vec%0d_flags", i), {29'b0, f}, {29'b0, vt[i].flags});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Stream of 8 ops (k + 1.0) with out_ready low for cycles 6..9
    @(negedge clk);
    tx = 0; rx = 0; stall_cycles = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      if (prev_stall) begin
        chk("stall_hold_sum", bus.sum, prev_sum);
        chk("stall_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = !(c >= 6 && c < 10);
      if (tx < 8) begin
        bus.in_valid = 1'b1; bus.a = fint[tx+1]; bus.b = fint[1]; bus.sub = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.sum;
      if (prev_stall) begin
        stall_cycles++;
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stream_sum%0d", rx), bus.sum, fint[rx+2]);
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 32'(rx), 32'd8);
    chk("stall_cycles", 32'(stall_cycles), 32'd4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stream_no_dup", {31'b0, bus.out_valid}, 32'd0);
    end

    // Reset while a result is stalled at the output
    bus.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c < 5);
      bus.a = fint[c+1]; bus.b = fint[1]; bus.sub = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_stalled", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_async_sum", bus.sum, 32'd0);
    chk("rst_async_flags", {29'b0, bus.flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'b0, bus.out_valid}, 32'd0);
    end
    run_one(fint[1], fint[2], 1'b0, res, f, lat);
    chk("post_rst_sum", res, fint[3]);
    chk("post_rst_latency", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/float_add_pipe.md
# float_add_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready handshake. It is the clocked successor to the combinational single-precision adder in the arithmetic unit. Exponent and mantissa widths are configurable, and it handles sign, exponent alignment, cancellation renormalisation, rounding, overflow and special operands. It sits between the operand-issue logic and the result writeback of the ALU.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored mantissa width, excluding the hidden bit (≥2).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in_valid`  input  1  operand pair present.
- `in_ready`  output  1  block accepts the operand pair this cycle.
- `a`, `b`  input  1+EXP_W+MAN_W  operands, packed {sign, exp, man}.
- `sub`  input  1  1 computes a−b; 0 computes a+b.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer takes the result this cycle.
- `sum`  output  1+EXP_W+MAN_W  packed result.
- `flags`  output  3  {invalid, overflow, inexact} for `sum`.

## Operation
- Transfer occurs on a rising edge where valid && ready.
- Effective sign of `b` is `b.sign ^ sub`.
- Special operands take priority:
  - exp==0 is treated as ±0 (flush-to-zero; subnormals become zero, inexact not set).
  - exp==all-ones is Inf; a nonzero mantissa there is NaN.
  - Any NaN operand, or Inf − Inf (effective signs differ), gives canonical NaN {0, all-ones, 1 followed by zeros} with invalid=1.
  - Inf with a finite operand gives that Inf.
  - Zero with X gives X. +0 + −0 gives +0; −0 + −0 gives −0.
- Stage 1 (align):
  - Swap so operand L has the larger magnitude, comparing {exp, man}.
  - Shift small significand (hidden 1 prepended) right by d = expL − expS into MAN_W+1 bits plus guard, round and sticky bits.
  - d ≥ MAN_W+3 leaves only sticky = 1.
- Stage 2 (add):
  - Add or subtract significands on MAN_W+5 bits; result sign = sign of L.
  - Exact cancellation gives +0.
- Stage 3 (normalise/pack):
  - On carry-out, shift right 1 and exp+1, folding the shifted-out bit into sticky.
  - Otherwise left-shift by the leading-zero count, exp−lzc.
  - Exp underflow (≤0) flushes to ±0 with inexact=1.
  - Round (see Configuration). A rounding carry renormalises and increments exp.
  - exp ≥ all-ones gives ±Inf with overflow=1 and inexact=1.
  - inexact=1 when any of guard, round or sticky is nonzero.
- Per-stage valid bits. Bubbles propagate; they do not block.

## Timing
- Latency is 3 cycles: operands accepted at edge N give `out_valid`=1 after edge N+3 when there is no stall.
- Throughput is one operation per cycle.
- stall = out_valid && !out_ready. While stall is asserted, every stage register and valid bit holds, and `sum`/`flags` stay stable.
- in_ready = !stall, combinational from `out_ready`/`out_valid`. There is no combinational path from `in_valid` to any output.
- Input accepted and output drained in the same cycle: both transfers occur and the pipeline advances.
- Reset: `out_valid`=0, `sum`=0, `flags`=0 and all stage valids=0. In-flight operations are discarded.
- Reset asserted mid-stall: the pending result is lost, and `in_ready`=1 on the first cycle after deassertion.

## Configuration
- `FLOAT_ADD_RNE_EN` defined: round-to-nearest, ties-to-even. Increment when G && (R || S || LSB).
- `FLOAT_ADD_RNE_EN` undefined: truncation (round toward zero). Guard, round and sticky are used only for the inexact flag, and rounding never causes overflow.
- Latency and interface are identical in both builds.

## Test plan
All scenarios use default parameters and `out_ready`=1 unless stated.
- Add: a=0x3F800000, b=0x40000000, sub=0 -> sum=0x40400000 with flags=000, 3 cycles later.
- Subtract: a=0x40400000, b=0x3F800000, sub=1 -> sum=0x40000000. Cancellation a=0x3F800000, b=0xBF800000, sub=0 -> sum=0x00000000.
- Rounding: a=0x3F800000, b=0x33C00000 -> sum=0x3F800001 with RNE, 0x3F800000 without. inexact=1 in both builds.
- Overflow: a=b=0x7F7FFFFF -> sum=0x7F800000, flags=011.
- Specials: 0x7F800000 − 0x7F800000 -> 0x7FC00000, flags=100. NaN 0x7F800001 + 1.0 -> 0x7FC00000, flags=100.
- Backpressure: stream 8 back-to-back operations with `out_ready` low for 4 cycles mid-stream. Require `in_ready`=0 during the stall, all 8 results in order, none duplicated, and `sum` stable while stalled. Assert `rst` mid-stream and require `out_valid`=0 immediately, with no stale result afterward.
